mem_bist_ctrl: RTL and testbench
================================

Name: mem_bist_ctrl

Overview:
Hardware memory test sequencer that sits directly upstream of the 32x8 synchronous memory and drives its read/write port in place of a testbench. On a start pulse it runs three fixed passes and accumulates mismatches: clear, data=address, and pseudo-random data. It reports pass/fail, an error count and the first failing location.

Parameters:
ADDR_W, 5, memory address width; depth = 2**ADDR_W; legal range 1..8.
READ_LATENCY, 1, cycles from the mem_read edge to valid mem_rdata; legal range 1..4.
LFSR_SEED, 8'hA5, LFSR reset/restart value; must be nonzero.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous reset, active-high.
start  in  1  one-cycle request; sampled only in IDLE or DONE.
busy  out  1  high while a test runs.
done  out  1  high from test end until the next start or rst.
pass  out  1  valid when done=1; 1 iff err_count==0.
phase  out  2  0=idle/done, 1=clear, 2=addr, 3=random.
err_count  out  8  total mismatches; saturates at 255.
fail_addr  out  ADDR_W  address of the first mismatch.
fail_data  out  8  read data at the first mismatch.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  8  memory write data.
mem_write  out  1  write strobe; one cycle per write.
mem_read  out  1  read strobe; one cycle per read.
mem_rdata  in  8  memory read data.

Behaviour:
- Reset (sync): state IDLE; all outputs are 0, and mem_read and mem_write are never both 1. The LFSR loads LFSR_SEED.
- An rst asserted mid-test aborts at the next edge with no further strobes.
- start seen in IDLE/DONE:
  - clears done, pass, err_count, fail_addr and fail_data;
  - reloads the LFSR;
  - next cycle: busy=1, first write issued.
- start while busy is ignored.
- States:
  - IDLE
  - CLR_WR, CLR_RD, CLR_WT
  - ADR_WR, ADR_RD, ADR_WT
  - RND_WR, RND_RD, RND_WT
  - DONE
- Write passes (CLR_WR, ADR_WR):
  - one write per cycle, addresses 0..DEPTH-1 ascending;
  - CLR data = 8'h00; ADR data = zero-extended address.
  - After the last address the FSM moves to the matching RD state at addr 0.
- Read-check (xx_RD):
  - assert mem_read for one cycle, then wait READ_LATENCY cycles in xx_WT;
  - sample mem_rdata on the final WT cycle and compare with !== semantics against the expected value;
  - increment the address and return to xx_RD, or after the last address go to the next pass;
  - cost 1+READ_LATENCY cycles/address.
- RND pass, per address:
  - RND_WR writes D, then RND_RD reads the same address, then RND_WT compares against D.
  - D = {1'b0, (l[6:5]==2'b00 ? 2'b01 : l[6:5]), l[4:0]}, where l = LFSR state, so D is always in 8'h20..8'h7F.
  - The LFSR advances once per RND_WR using Galois x^8+x^6+x^5+x^4+1.
- Mismatch handling:
  - err_count += 1, saturating at 255;
  - on the first mismatch of a run, latch fail_addr and fail_data.
- Completion:
  - total busy cycles = DEPTH*(6+3*READ_LATENCY), which is 288 for the defaults;
  - then state DONE: busy=0, done=1, pass=(err_count==0), phase=0, until start or rst.
- mem_addr and mem_wdata hold their last values when no strobe is active.

Test Plan:
1. Fault-free memory model, defaults, start pulse:
   - busy high for exactly 288 cycles;
   - done=1, pass=1, err_count=0;
   - 96 writes and 96 reads observed.
2. Memory returns 8'hFF at address 5 only:
   - err_count=3 (one per pass), pass=0;
   - fail_addr=5, fail_data=8'hFF.
3. Data bit 0 stuck at 0:
   - CLR pass adds 0, ADR pass adds 16;
   - RND adds the count of odd D values, which the bench reference model computes;
   - fail_addr=1, fail_data=8'h00.
4. rst asserted at cycle 150 of the test:
   - next edge: all outputs 0, no strobes;
   - a subsequent start runs a full, fault-free 288-cycle test with pass=1.
5. start re-pulsed at cycles 10 and 200 while busy: no effect, and done still arrives at cycle 288.
6. READ_LATENCY=3:
   - busy lasts 32*15=480 cycles;
   - each compare happens 3 cycles after its mem_read;
   - the RND write data sequence is identical to the default run.

Source files
------------

// File: rtl/mem_bist_ctrl.sv
// Memory BIST sequencer: clear, data=address and pseudo-random passes over a synchronous
// memory, counting read-back mismatches and latching the first failing location.
module mem_bist_ctrl #(
    parameter int         ADDR_W       = 5,
    parameter int         READ_LATENCY = 1,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        phase,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [7:0]        fail_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [7:0]        mem_rdata
);

    // state  | meaning
    // IDLE   | waiting for start after reset
    // xx_WR  | one write per cycle (CLR/ADR sweep; RND one write per address)
    // xx_RD  | read strobe for the current address
    // xx_WT  | read latency wait, compare on the last cycle
    // DONE   | results held until start or rst
    typedef enum logic [3:0] {
        S_IDLE, S_CLR_WR, S_CLR_RD, S_CLR_WT, S_ADR_WR, S_ADR_RD, S_ADR_WT,
        S_RND_WR, S_RND_RD, S_RND_WT, S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [2:0]        WT_LOAD   = 3'(READ_LATENCY - 1);

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
    endfunction

    // Forces bits 6:5 away from 00 so the pattern stays in 8'h20..8'h7F.
    function automatic logic [7:0] rnd_data(input logic [7:0] l);
        return {1'b0, (l[6:5] == 2'b00) ? 2'b01 : l[6:5], l[4:0]};
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
    logic [2:0]        wt_q, wt_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [1:0]        phase_q, phase_d;
    logic [7:0]        err_q, err_d, fail_data_q, fail_data_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d, mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_write_q, mem_write_d, mem_read_q, mem_read_d;
    logic [7:0]        exp_data;
    logic              check;

    assign addr_inc = addr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wt_d        = wt_q;
        lfsr_d      = lfsr_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        phase_d     = phase_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        exp_data    = 8'h00;
        check       = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_CLR_WR;
                    addr_d      = '0;
                    lfsr_d      = LFSR_SEED;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    phase_d     = 2'd1;
                    err_d       = 8'h00;
                    fail_addr_d = '0;
                    fail_data_d = 8'h00;
                    mem_addr_d  = '0;
                    mem_wdata_d = 8'h00;
                    mem_write_d = 1'b1;
                end
            end
            S_CLR_WR, S_ADR_WR: begin
                if (addr_q == LAST_ADDR) begin
                    state_d    = (state_q == S_CLR_WR) ? S_CLR_RD : S_ADR_RD;
                    addr_d     = '0;
                    mem_addr_d = '0;
                    mem_read_d = 1'b1;
                end else begin
                    addr_d      = addr_inc;
                    mem_addr_d  = addr_inc;
                    mem_wdata_d = (state_q == S_CLR_WR) ? 8'h00 : 8'(addr_inc);
                    mem_write_d = 1'b1;
                end
            end
            S_RND_WR: begin
                state_d    = S_RND_RD;
                mem_read_d = 1'b1;
            end
            S_CLR_RD: begin state_d = S_CLR_WT; wt_d = WT_LOAD; end
            S_ADR_RD: begin state_d = S_ADR_WT; wt_d = WT_LOAD; end
            S_RND_RD: begin state_d = S_RND_WT; wt_d = WT_LOAD; end
            S_CLR_WT, S_ADR_WT, S_RND_WT: begin
                if (wt_q != 3'd0) begin
                    wt_d = wt_q - 3'd1;
                end else begin
                    check = 1'b1;
                    // RND expected data is the value still held on mem_wdata from RND_WR.
                    if (state_q == S_CLR_WT)      exp_data = 8'h00;
                    else if (state_q == S_ADR_WT) exp_data = 8'(addr_q);
                    else                          exp_data = mem_wdata_q;
                    if (addr_q != LAST_ADDR) begin
                        addr_d     = addr_inc;
                        mem_addr_d = addr_inc;
                        if (state_q == S_RND_WT) begin
                            state_d     = S_RND_WR;
                            mem_wdata_d = rnd_data(lfsr_q);
                            lfsr_d      = lfsr_next(lfsr_q);
                            mem_write_d = 1'b1;
                        end else begin
                            state_d    = (state_q == S_CLR_WT) ? S_CLR_RD : S_ADR_RD;
                            mem_read_d = 1'b1;
                        end
                    end else begin
                        addr_d     = '0;
                        mem_addr_d = '0;
                        if (state_q == S_CLR_WT) begin
                            state_d     = S_ADR_WR;
                            phase_d     = 2'd2;
                            mem_wdata_d = 8'h00;
                            mem_write_d = 1'b1;
                        end else if (state_q == S_ADR_WT) begin
                            state_d     = S_RND_WR;
                            phase_d     = 2'd3;
                            mem_wdata_d = rnd_data(lfsr_q);
                            lfsr_d      = lfsr_next(lfsr_q);
                            mem_write_d = 1'b1;
                        end else begin
                            state_d    = S_DONE;
                            phase_d    = 2'd0;
                            busy_d     = 1'b0;
                            done_d     = 1'b1;
                            mem_addr_d = mem_addr_q;
                            addr_d     = addr_q;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (check && (mem_rdata !== exp_data)) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (err_q == 8'h00) begin
                fail_addr_d = addr_q;
                fail_data_d = mem_rdata;
            end
        end
        if (state_d == S_DONE && state_q != S_DONE) pass_d = (err_d == 8'h00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wt_q        <= 3'd0;
            lfsr_q      <= LFSR_SEED;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            phase_q     <= 2'd0;
            err_q       <= 8'h00;
            fail_addr_q <= '0;
            fail_data_q <= 8'h00;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wt_q        <= wt_d;
            lfsr_q      <= lfsr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            phase_q     <= phase_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign phase     = phase_q;
    assign err_count = err_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_write = mem_write_q;
    assign mem_read  = mem_read_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: two instances (read latency 1 and 3) each driving a faultable
// memory model; results are checked against a pass-by-pass reference model.
module tb_mem_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v   [2];
    logic       start_v [2];
    logic       busy_v  [2];
    logic       done_v  [2];
    logic       pass_v  [2];
    logic [1:0] phase_v [2];
    logic [7:0] err_v   [2];
    logic [4:0] fa_v    [2];
    logic [7:0] fd_v    [2];
    logic [4:0] maddr_v [2];
    logic [7:0] mwd_v   [2];
    logic       mwr_v   [2];
    logic       mrd_v   [2];
    logic [7:0] rdata_v [2];

    bit         bad_en;
    int         bad_addr;
    logic [7:0] bad_val, and_m, or_m;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // What the faulty memory returns for a stored value.
    function automatic logic [7:0] fault_rd(input int a, input logic [7:0] d);
        if (bad_en && a == bad_addr) return bad_val;
        return (d & and_m) | or_m;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int RL = (g == 0) ? 1 : 3;
        logic [7:0] mem [32];
        logic [7:0] pd  [RL];
        logic       pv  [RL];

        initial for (int k = 0; k < RL; k++) pv[k] = 1'b0;

        always @(posedge clk) begin
            if (mwr_v[g]) mem[maddr_v[g]] <= mwd_v[g];
            pv[0] <= mrd_v[g];
            pd[0] <= fault_rd(int'(maddr_v[g]), mem[maddr_v[g]]);
            for (int k = 1; k < RL; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
        end
        // Data is only correct in the exact cycle the latency promises.
        assign rdata_v[g] = pv[RL-1] ? pd[RL-1] : 8'hEE;

        mem_bist_ctrl #(.ADDR_W(5), .READ_LATENCY(RL), .LFSR_SEED(8'hA5)) dut (
            .clk(clk), .rst(rst_v[g]), .start(start_v[g]), .busy(busy_v[g]),
            .done(done_v[g]), .pass(pass_v[g]), .phase(phase_v[g]),
            .err_count(err_v[g]), .fail_addr(fa_v[g]), .fail_data(fd_v[g]),
            .mem_addr(maddr_v[g]), .mem_wdata(mwd_v[g]), .mem_write(mwr_v[g]),
            .mem_read(mrd_v[g]), .mem_rdata(rdata_v[g])
        );
    end

    int sel = 0;
    int busy_cnt, rd_cnt, both_cnt;
    int wq_a[$];
    int wq_d[$];

    always @(negedge clk) begin
        if (busy_v[sel]) busy_cnt++;
        if (mwr_v[sel]) begin
            wq_a.push_back(int'(maddr_v[sel]));
            wq_d.push_back(int'(mwd_v[sel]));
        end
        if (mrd_v[sel]) rd_cnt++;
        if (mwr_v[sel] && mrd_v[sel]) both_cnt++;
    end

    int exp_err, exp_fa, exp_fd;
    int ew_a[$];
    int ew_d[$];

    function automatic void note_read(input int a, input logic [7:0] d);
        logic [7:0] r;
        r = fault_rd(a, d);
        if (r !== d) begin
            if (exp_err == 0) begin
                exp_fa = a;
                exp_fd = int'(r);
            end
            if (exp_err < 255) exp_err++;
        end
    endfunction

    task automatic ref_model();
        logic [7:0] l, d;
        exp_err = 0; exp_fa = 0; exp_fd = 0;
        ew_a.delete(); ew_d.delete();
        for (int a = 0; a < 32; a++) begin ew_a.push_back(a); ew_d.push_back(0); end
        for (int a = 0; a < 32; a++) note_read(a, 8'h00);
        for (int a = 0; a < 32; a++) begin ew_a.push_back(a); ew_d.push_back(a); end
        for (int a = 0; a < 32; a++) note_read(a, 8'(a));
        l = 8'hA5;
        for (int a = 0; a < 32; a++) begin
            d = {1'b0, (l[6:5] == 2'b00) ? 2'b01 : l[6:5], l[4:0]};
            ew_a.push_back(a); ew_d.push_back(int'(d));
            note_read(a, d);
            l = (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
        end
    endtask

    task automatic chk_zero(input string nm, input int s);
        chk({nm, "_busy0"}, int'(busy_v[s]), 0);
        chk({nm, "_done0"}, int'(done_v[s]), 0);
        chk({nm, "_pass0"}, int'(pass_v[s]), 0);
        chk({nm, "_phase0"}, int'(phase_v[s]), 0);
        chk({nm, "_err0"}, int'(err_v[s]), 0);
        chk({nm, "_fa0"}, int'(fa_v[s]), 0);
        chk({nm, "_fd0"}, int'(fd_v[s]), 0);
        chk({nm, "_maddr0"}, int'(maddr_v[s]), 0);
        chk({nm, "_mwd0"}, int'(mwd_v[s]), 0);
        chk({nm, "_strobes0"}, int'({mwr_v[s], mrd_v[s]}), 0);
    endtask

    task automatic run_test(input int s, input string nm, input int p1, input int p2,
                            input int abort_at);
        int exp_busy, cyc, nbad;
        exp_busy = 32 * (6 + 3 * ((s == 0) ? 1 : 3));
        ref_model();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1;
        sel = s;
        busy_cnt = 0; rd_cnt = 0; both_cnt = 0;
        wq_a.delete(); wq_d.delete();
        start_v[s] = 1'b1;
        @(posedge clk); #1;
        start_v[s] = 1'b0;
        cyc = 1;
        while (!done_v[s] && cyc < exp_busy + 50) begin
            start_v[s] = (cyc == p1 || cyc == p2);
            if (cyc == abort_at) begin
                rst_v[s] = 1'b1;
                @(posedge clk); #1;
                chk_zero({nm, "_abort"}, s);
                @(posedge clk); #1;
                chk({nm, "_abort_strobes"}, int'({mwr_v[s], mrd_v[s]}), 0);
                rst_v[s] = 1'b0;
                return;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_v[s] = 1'b0;
        chk({nm, "_done"}, int'(done_v[s]), 1);
        chk({nm, "_done_cyc"}, cyc - 1, exp_busy);
        chk({nm, "_busy_cnt"}, busy_cnt, exp_busy);
        chk({nm, "_busy_end"}, int'(busy_v[s]), 0);
        chk({nm, "_phase"}, int'(phase_v[s]), 0);
        chk({nm, "_err"}, int'(err_v[s]), exp_err);
        chk({nm, "_pass"}, int'(pass_v[s]), (exp_err == 0) ? 1 : 0);
        chk({nm, "_fail_addr"}, int'(fa_v[s]), exp_fa);
        chk({nm, "_fail_data"}, int'(fd_v[s]), exp_fd);
        chk({nm, "_writes"}, wq_a.size(), 96);
        chk({nm, "_reads"}, rd_cnt, 96);
        chk({nm, "_both_strobes"}, both_cnt, 0);
        nbad = 0;
        for (int i = 0; i < 96 && i < wq_a.size(); i++)
            if (wq_a[i] != ew_a[i] || wq_d[i] != ew_d[i]) nbad++;
        chk({nm, "_wr_seq"}, nbad, 0);
    endtask

    task automatic set_fault(input bit en, input int a, input logic [7:0] v,
                             input logic [7:0] am, input logic [7:0] om);
        bad_en = en; bad_addr = a; bad_val = v; and_m = am; or_m = om;
    endtask

    initial begin
        rst_v[0] = 1'b1; rst_v[1] = 1'b1;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        set_fault(0, 0, 8'h00, 8'hFF, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        @(posedge clk); #1;
        chk_zero("reset", 0);
        chk("reset_busy1", int'(busy_v[1]), 0);

        run_test(0, "t1_clean", 0, 0, 0);
        set_fault(1, 5, 8'hFF, 8'hFF, 8'h00);
        run_test(0, "t2_addr5", 0, 0, 0);
        chk("t2_exp_err", exp_err, 3);
        set_fault(0, 0, 8'h00, 8'hFE, 8'h00);
        run_test(0, "t3_stuck0", 0, 0, 0);
        set_fault(0, 0, 8'h00, 8'hFF, 8'h00);
        run_test(0, "t4_abort", 0, 0, 150);
        run_test(0, "t4_rerun", 0, 0, 0);
        run_test(0, "t5_restart", 10, 200, 0);
        run_test(1, "t6_rl3", 0, 0, 0);
        set_fault(1, 5, 8'hFF, 8'hFF, 8'h00);
        run_test(1, "t6_rl3_addr5", 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            set_fault(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 8'($urandom),
                      ($urandom_range(0, 1) != 0) ? 8'hFF : ~(8'h01 << $urandom_range(0, 7)),
                      ($urandom_range(0, 2) != 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7)));
            run_test(i % 2, $sformatf("rnd%0d", i), 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
